// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise logic unit (8 ops) in a 2-stage elastic valid/ready pipeline,
// with zero/all-ones/parity flags and a wrapping completed-operation counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             f_zero,
  output logic             f_ones,
  output logic             f_parity,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    case (sel)
      OP_NAND: res = ~(a & b);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      default: res = a;
    endcase
    return res;
  endfunction

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_x_p1;
  logic [WIDTH-1:0] r_y_p1;
  logic [2:0]       r_op_p1;

  logic             r_vld_p2;
  logic [WIDTH-1:0] r_o_p2;
  logic             r_zero_p2;
  logic             r_ones_p2;
  logic             r_par_p2;
  logic [CNT_W-1:0] r_cnt;

  logic             w_adv2;
  logic             w_adv1;
  logic [WIDTH-1:0] w_res_p1;

  // Each stage may load whenever it is empty or its successor is draining,
  // so in_ready is combinational from out_ready.
  assign w_adv2   = !r_vld_p2 || out_ready;
  assign w_adv1   = !r_vld_p1 || w_adv2;
  assign in_ready = w_adv1;
  assign w_res_p1 = logic_op(r_op_p1, r_x_p1, r_y_p1);

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_adv1) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      r_x_p1  <= x;
      r_y_p1  <= y;
      r_op_p1 <= op;
    end
  end

  // ---- Stage 2: result and flags (held on stall and across bubbles) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_o_p2    <= '0;
      r_zero_p2 <= 1'b0;
      r_ones_p2 <= 1'b0;
      r_par_p2  <= 1'b0;
    end else if (w_adv2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_o_p2    <= w_res_p1;
        r_zero_p2 <= ~|w_res_p1;
        r_ones_p2 <= &w_res_p1;
        r_par_p2  <= ^w_res_p1;
      end
    end
  end

  // ---- Completed-operation counter, wraps silently ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_vld_p2 && out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_vld_p2;
  assign o         = r_o_p2;
  assign f_zero    = r_zero_p2;
  assign f_ones    = r_ones_p2;
  assign f_parity  = r_par_p2;
  assign op_count  = r_cnt;

endmodule
